// File: rtl/draw_pkg.sv
// Shared types and constants for the framebuffer draw scheduler.
package draw_pkg;

   typedef enum logic [1:0] {IDLE, ARM, DRAW, DRAIN} state_t;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int X_W      = 9;
   localparam int Y_W      = 8;
   localparam int C_W      = 3;

   localparam logic [C_W-1:0] TRANSPARENT_COLOUR_DEF = 3'b101;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] grant_id,
   output logic           grant_valid
);

   // Walk offsets from the far end so the nearest set bit to ptr wins last.
   always_comb begin
      int idx;
      idx         = 0;
      grant_id    = '0;
      grant_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            grant_id    = IDW'(idx);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates the VGA plot port between N drawer blocks, one job at a time.
// Build option: define DRAW_TRANSPARENT_EN to suppress plots of the colour key.
module draw_scheduler
   import draw_pkg::*;
#(
   parameter int             N                  = 4,
   parameter int             IDW                = 2,
   parameter logic [C_W-1:0] TRANSPARENT_COLOUR = TRANSPARENT_COLOUR_DEF
) (
   input  logic               clock_all,
   input  logic               reset_all,
   input  logic [N-1:0]       req,
   output logic [N-1:0]       ack,
   output logic [N-1:0]       drw_enable,
   output logic [N-1:0]       drw_reset_n,
   input  logic [N*X_W-1:0]   drw_x,
   input  logic [N*Y_W-1:0]   drw_y,
   input  logic [N*C_W-1:0]   drw_colour,
   input  logic [N-1:0]       drw_done,
   output logic [X_W-1:0]     vga_x,
   output logic [Y_W-1:0]     vga_y,
   output logic [C_W-1:0]     vga_colour,
   output logic               vga_plot,
   output logic               busy,
   output logic [IDW-1:0]     active_id
);

`ifdef DRAW_TRANSPARENT_EN
   localparam bit KEY_EN = 1'b1;
`else
   localparam bit KEY_EN = 1'b0;
`endif

   state_t          state, state_n;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  grant_id;
   logic            grant_valid;
   logic [X_W-1:0]  stage_x;
   logic [Y_W-1:0]  stage_y;
   logic            plot_pipe;
   logic [X_W-1:0]  sel_x;
   logic [Y_W-1:0]  sel_y;
   logic [C_W-1:0]  sel_colour;
   logic            sel_done;

   rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
      .req         (req),
      .ptr         (ptr),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   assign sel_x      = drw_x[X_W*int'(active_id) +: X_W];
   assign sel_y      = drw_y[Y_W*int'(active_id) +: Y_W];
   assign sel_colour = drw_colour[C_W*int'(active_id) +: C_W];
   assign sel_done   = drw_done[active_id];

   // State, grant, pointer and the one-cycle x/y stage that aligns with the ROM.
   always_ff @(posedge clock_all) begin
      if (reset_all) begin
         state     <= IDLE;
         active_id <= '0;
         ptr       <= '0;
         stage_x   <= '0;
         stage_y   <= '0;
         plot_pipe <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && grant_valid)
            active_id <= grant_id;
         if (state == DRAIN)
            ptr <= (active_id == IDW'(N - 1)) ? '0 : active_id + 1'b1;
         if (state == DRAW) begin
            stage_x <= sel_x;
            stage_y <= sel_y;
         end
         plot_pipe <= (state == DRAW);
      end
   end

   // Next state and per-drawer handshakes; only the granted drawer is ever released.
   always_comb begin
      state_n     = state;
      drw_enable  = '0;
      drw_reset_n = '0;
      ack         = '0;
      case (state)
         IDLE:  if (grant_valid) state_n = ARM;
         ARM: begin
            drw_reset_n[active_id] = 1'b1;
            state_n                = DRAW;
         end
         DRAW: begin
            drw_reset_n[active_id] = 1'b1;
            drw_enable[active_id]  = 1'b1;
            if (sel_done) state_n = DRAIN;
         end
         DRAIN: begin
            ack[active_id] = 1'b1;
            state_n        = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Colour is only meaningful while a staged pixel is pending, so zero it otherwise.
   assign vga_x      = stage_x;
   assign vga_y      = stage_y;
   assign vga_colour = plot_pipe ? sel_colour : '0;
   assign vga_plot   = plot_pipe & ~(KEY_EN & (vga_colour == TRANSPARENT_COLOUR));
   assign busy       = (state != IDLE);

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Arbitrates the single VGA framebuffer write port between N full-screen/sprite drawer blocks (title screen, battle background, sprites, health bars).
- Grants one drawer at a time, drives that drawer's enable and active-low counter reset, and forwards its pixel stream to the VGA adapter.
- Delays the drawer x/y by one cycle so they line up with the registered ROM colour output.
- Sits between the game FSM, which raises draw requests, and the vga_adapter plot interface.

Parameters:
- N, 4, number of drawer requesters (2..8).
- IDW, 2, width of the active-ID field, equal to clog2(N), minimum 1.
- TRANSPARENT_COLOUR, 3'b101, colour key suppressed when DRAW_TRANSPARENT_EN is defined.

Ports:
- clock_all  in  1  system clock.
- reset_all  in  1  synchronous active-high reset.
- req  in  N  per-drawer draw request; level, held until ack.
- ack  out  N  one-cycle pulse when the drawer's final pixel has been plotted.
- drw_enable  out  N  enable to the granted drawer; one-hot or zero.
- drw_reset_n  out  N  active-low counter reset to each drawer.
- drw_x  in  N*9  packed drawer x (drawer i occupies bits [9i+8:9i]); combinational from drawer counters.
- drw_y  in  N*8  packed drawer y.
- drw_colour  in  N*3  packed ROM colour; one-cycle latency relative to x/y.
- drw_done  in  N  drawer last-pixel flag, same cycle as last x/y.
- vga_x  out  9  plot x.
- vga_y  out  8  plot y.
- vga_colour  out  3  plot colour.
- vga_plot  out  1  write strobe.
- busy  out  1  high in any state other than IDLE.
- active_id  out  IDW  index of the granted drawer; holds its last value when idle.

Behaviour:
- Reset: state is IDLE. ack, drw_enable, vga_plot and busy are 0. drw_reset_n is all 0, so all drawer counters are held. vga_x, vga_y, vga_colour and active_id are 0. The round-robin pointer is 0.
- State IDLE:
  - drw_reset_n is all 0.
  - If any req is set, pick the first set bit searching upward from the pointer, wrapping modulo N.
  - Latch the pick into active_id and go to ARM.
  - Any request pending at the cycle after an ack is serviced.
- State ARM (1 cycle):
  - drw_reset_n[active_id] = 1; drw_enable = 0. This guarantees the drawer counters start at 0.
  - Go to DRAW.
- State DRAW:
  - drw_enable[active_id] = 1.
  - Every cycle, register x/y of active_id into a stage register and set plot_pipe = 1.
  - On the next cycle, vga_x/vga_y come from the stage register and vga_colour from drw_colour[active_id], with vga_plot = plot_pipe. That gives 1-cycle pixel latency from drawer x/y to plot.
  - When drw_done[active_id] = 1, go to DRAIN.
- State DRAIN (1 cycle):
  - drw_enable = 0; drw_reset_n[active_id] = 0.
  - vga_plot = 1 for the final pixel.
  - Pulse ack[active_id]; set the pointer to (active_id+1) mod N; go to IDLE.
- Pixel count per job: exactly the number of cycles spent in DRAW. A 320x240 drawer gives 76800 plots.
- req dropped mid-job: ignored; the job runs to completion.
- req for the active drawer still high after ack: re-arbitrated fairly, so other pending requesters win first.
- Simultaneous requests: round-robin order.
- Non-granted drawers: drw_enable = 0 and drw_reset_n = 0.
- drw_done of a non-granted drawer: ignored.
- Reset mid-job: returns to IDLE within 1 cycle with the reset values above. No ack is issued and the aborted frame is not resumed.
- vga_plot is never high in IDLE or ARM.

Optional Feature:
- Macro: DRAW_TRANSPARENT_EN.
- Defined: vga_plot is forced to 0 whenever vga_colour == TRANSPARENT_COLOUR. Sprites can therefore overlay the background. Job length and ack timing are unchanged.
- Undefined: every pixel is plotted.

Decomposition:
- Package draw_pkg holds:
  - state enum (IDLE, ARM, DRAW, DRAIN);
  - SCREEN_W = 320, SCREEN_H = 240;
  - X_W = 9, Y_W = 8, C_W = 3;
  - the default TRANSPARENT_COLOUR.
- One sub-module, rr_arbiter: combinational round-robin priority pick.
  - Inputs: req and pointer.
  - Outputs: grant index and grant-valid.

Test Plan:
- Single job: N=4 with a 4x2 stub drawer model on port 1 (1-cycle ROM, colour = x+y). Raise req[1] -> ARM, then 8 DRAW cycles, 8 plots at (0,0)..(3,1) with colour matching the coordinates one cycle after x/y. ack[1] pulses once in the DRAIN cycle; busy is high for 10 cycles.
- Round-robin: req = 4'b1011 held -> grant order 0, 1, 3, 0. Each ack is followed by IDLE, then ARM of the next drawer. drw_enable is never more than one bit.
- Reset mid-job: assert reset_all at the 5th DRAW cycle -> next cycle state is IDLE, vga_plot = 0, drw_reset_n = 0, no ack. Re-request -> first plot is again at (0,0).
- Full screen: 320x240 drawer on port 0 -> exactly 76800 plots. The last plot is at (319,239), and ack[0] coincides with it.
- Transparency (macro defined): stub outputs colour 3'b101 on every odd x -> only even-x pixels are plotted (4 of 8). Ack timing is identical to the first scenario.
- Request drop: deassert req[2] after ARM -> the job still completes with ack[2], and no re-grant of drawer 2.
